frsim_toggle_gen: RTL and testbench
===================================

# frsim_toggle_gen

Parametrised multi-channel toggle/stimulus generator for FrSim co-simulation benches. It replaces hand-written per-bench clock-divider and run-length logic with one synthesisable block. It drives CHANNELS independent divided toggle outputs from one clock, and ends each run after a programmable cycle budget by raising `done`. The bench's `$finish` / `$frsim_system` harness watches `done`.

## Interface
- `CHANNELS`, default 4: number of independent toggle channels.
- `DIV_W`, default 8: width of each channel's divide and phase fields.
- `RUN_W`, default 16: width of the run-length limit and cycle counter.

Ports:
- `clk` in 1: single clock for all logic.
- `rst` in 1: reset, synchronous and active-high.
- `start` in 1: level-sampled; starts a run when the block is IDLE or DONE.
- `enable` in CHANNELS: per-channel run enable.
- `div` in CHANNELS*DIV_W: per-channel half-period minus 1; channel i uses bits [i*DIV_W +: DIV_W].
- `phase` in CHANNELS*DIV_W: per-channel initial counter value. Present only with `FRSIM_TOGGLE_PHASE_EN`.
- `run_limit` in RUN_W: RUN cycles before `done`; 0 means free-run.
- `tog` out CHANNELS: toggle outputs.
- `edge` out CHANNELS: one-cycle pulse in the cycle after each `tog` flip.
- `cycles` out RUN_W: RUN cycles elapsed.
- `busy` out 1: high while in RUN.
- `done` out 1: high while in DONE.

## Operation
- FSM states are IDLE, RUN and DONE.
- IDLE→RUN when `start`=1. At that edge the block clears `cycles` to 0 and loads every channel counter with 0, or with `phase[i]` when the macro is defined. `tog` is not cleared.
- RUN→DONE at the edge where `cycles == run_limit-1` and `run_limit != 0`.
- With `run_limit`=0 the block stays in RUN until `rst`, and `cycles` wraps modulo 2^RUN_W.
- DONE→RUN when `start`=1, with the same reload as from IDLE.
- `start` is ignored while in RUN.
- Channel i in RUN with `enable[i]`=1, evaluated at each edge:
  - If `cnt[i] >= div[i]`: `cnt[i]`←0, `tog[i]`←~`tog[i]`, `edge[i]`←1.
  - Otherwise: `cnt[i]`←`cnt[i]`+1, `edge[i]`←0.
- Resulting `tog[i]` period is 2*(`div[i]`+1) cycles; `div`=0 gives clk/2.
- Channel i in RUN with `enable[i]`=0: `cnt` and `tog` hold, and `edge[i]`=0.
- Changing `div` mid-run takes effect immediately. If `cnt` is already at or above the new `div`, the channel toggles at the next edge because the compare is `>=`.
- In IDLE and DONE all counters, `tog` and `cycles` hold, and `edge`=0.
- `rst` overrides every other input, in any state.

## Timing
- Reset values: state IDLE, `tog`=0, `edge`=0, `cycles`=0, `busy`=0, `done`=0, all counters 0.
- `start` is sampled at edge S.
  - `busy`=1 from cycle S+1.
  - `cycles` reads k during RUN cycle k+1.
- A channel with counter initial value p ≤ d and `div`=d, enabled throughout:
  - First flip of `tog` is registered at edge S+1+(d-p).
  - `edge` is high for exactly one cycle, coincident with the new `tog` value.
- With `run_limit`=L>0: `busy` is high for exactly L cycles, then `done`=1 from cycle S+L+1. Channels still act at the final RUN edge.
- `start`=1 held continuously: the block restarts on the first cycle of DONE, so `done` pulses for 1 cycle.
- All outputs are registered, with no combinational input-to-output paths.

## Configuration
- `FRSIM_TOGGLE_PHASE_EN`: compiles in the `phase` port and the per-channel phase load at start.
  - If `phase[i] > div[i]`, the first edge in RUN toggles.
- Without the macro the `phase` port does not exist and all counters load 0 at start.

## Test plan
- Reset: assert `rst` mid-RUN with `tog`=4'b1010 → next cycle `tog`=0, `cycles`=0, `busy`=0, `done`=0; `start` ignored while `rst`=1.
- Divide ratios: `div`={3,2,1,0}, `enable`=4'hF, `run_limit`=40, start at S → `tog[0]` period 2 and `tog[3]` period 8. `tog[3]` first flips at S+4, `edge[3]` pulses at S+4, S+8, … .
- Run length: `run_limit`=10 → `busy` for exactly 10 cycles, `cycles`=9 in the last, `done`=1 from S+11 and held. A second `start` restarts with `cycles`=0; `run_limit`=0 runs past 2^RUN_W cycles with `cycles` wrapping and `done` never asserted.
- Enable/div change: deassert `enable[1]` for 5 cycles mid-run → `tog[1]` and its counter frozen, phase resumes unchanged. Lower `div[2]` from 7 to 2 when `cnt[2]`=5 → toggle at the next edge.
- Phase (macro on): `div`=3, `phase`={0,1,2,3} → first flips at S+4, S+3, S+2, S+1 respectively. `phase`=5 with `div`=3 → flip at S+1.

Source files
------------

// File: rtl/frsim_toggle_gen.sv
// frsim_toggle_gen: CHANNELS divided toggle outputs plus a run-length
// budget that raises done_o when the budget is spent.
// Ports: clk_i/rst_i (sync, active-high), start_i, enable_i, div_i,
//   phase_i (only with FRSIM_TOGGLE_PHASE_EN), run_limit_i;
//   tog_o, edge_o, cycles_o, busy_o, done_o (all registered).
// Optional macro: FRSIM_TOGGLE_PHASE_EN adds phase_i and its start load.
module frsim_toggle_gen #(
  parameter int CHANNELS = 4,
  parameter int DIV_W    = 8,
  parameter int RUN_W    = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  input  logic [CHANNELS-1:0]       enable_i,
  input  logic [CHANNELS*DIV_W-1:0] div_i,
`ifdef FRSIM_TOGGLE_PHASE_EN
  input  logic [CHANNELS*DIV_W-1:0] phase_i,
`endif
  input  logic [RUN_W-1:0]          run_limit_i,
  output logic [CHANNELS-1:0]       tog_o,
  output logic [CHANNELS-1:0]       edge_o,
  output logic [RUN_W-1:0]          cycles_o,
  output logic                      busy_o,
  output logic                      done_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  state_e state_q, state_d;
  logic   load;

  logic [CHANNELS-1:0][DIV_W-1:0] cnt_q, cnt_d;
  logic [CHANNELS-1:0]            tog_q, tog_d;
  logic [CHANNELS-1:0]            edge_q, edge_d;
  logic [RUN_W-1:0]               cyc_q, cyc_d;
  logic                           busy_q, done_q;

  logic last_run;
  assign last_run = (run_limit_i != '0) &&
                    (cyc_q == run_limit_i - RUN_W'(1));

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          state_d = ST_RUN;
          load    = 1'b1;
        end
      end
      ST_RUN: begin
        if (last_run) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    tog_d  = tog_q;
    edge_d = '0;
    cyc_d  = cyc_q;
    if (load) begin
      cyc_d = '0;
      for (int i = 0; i < CHANNELS; i++) begin
`ifdef FRSIM_TOGGLE_PHASE_EN
        cnt_d[i] = phase_i[i*DIV_W +: DIV_W];
`else
        cnt_d[i] = '0;
`endif
      end
    end else if (state_q == ST_RUN) begin
      cyc_d = cyc_q + RUN_W'(1);
      for (int i = 0; i < CHANNELS; i++) begin
        if (enable_i[i]) begin
          // >= so a div lowered below the live count flips at once
          if (cnt_q[i] >= div_i[i*DIV_W +: DIV_W]) begin
            cnt_d[i]  = '0;
            tog_d[i]  = ~tog_q[i];
            edge_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + DIV_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      tog_q   <= '0;
      edge_q  <= '0;
      cyc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tog_q   <= tog_d;
      edge_q  <= edge_d;
      cyc_q   <= cyc_d;
      busy_q  <= (state_d == ST_RUN);
      done_q  <= (state_d == ST_DONE);
    end
  end

  assign tog_o    = tog_q;
  assign edge_o   = edge_q;
  assign cycles_o = cyc_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;

endmodule

// File: tb/tb_frsim_toggle_gen.sv
// Bench for frsim_toggle_gen: cycle model feeds a scoreboard queue,
// plus fixed timing expectations for each scenario.
module tb_frsim_toggle_gen;
  localparam int C  = 4;
  localparam int DW = 8;
  localparam int RW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [C-1:0]  enable;
  logic [C*DW-1:0] div;
`ifdef FRSIM_TOGGLE_PHASE_EN
  logic [C*DW-1:0] phase;
`endif
  logic [RW-1:0] run_limit;
  logic [C-1:0]  tog_o, edge_o;
  logic [RW-1:0] cycles_o;
  logic          busy_o, done_o;

  always #5 clk = ~clk;

  frsim_toggle_gen #(.CHANNELS(C), .DIV_W(DW), .RUN_W(RW)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .enable_i(enable), .div_i(div),
`ifdef FRSIM_TOGGLE_PHASE_EN
    .phase_i(phase),
`endif
    .run_limit_i(run_limit),
    .tog_o(tog_o), .edge_o(edge_o), .cycles_o(cycles_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  typedef logic [2*C+RW+1:0] vec_t;
  vec_t sbq[$];
  vec_t e, got;
  int n_cmp = 0;
  int n_bad = 0;

  int       m_state;
  int       m_cnt[C];
  logic [C-1:0] m_tog, m_edge;
  int       m_cyc;

  // Model one edge from current inputs, push expectation, advance.
  task automatic step();
    if (rst) begin
      m_state = 0; m_tog = '0; m_edge = '0; m_cyc = 0;
      for (int i = 0; i < C; i++) m_cnt[i] = 0;
    end else begin
      m_edge = '0;
      if (m_state == 1) begin
        for (int i = 0; i < C; i++) begin
          if (enable[i]) begin
            if (m_cnt[i] >= int'(div[i*DW +: DW])) begin
              m_cnt[i] = 0;
              m_tog[i] = ~m_tog[i];
              m_edge[i] = 1'b1;
            end else m_cnt[i] = m_cnt[i] + 1;
          end
        end
        if (run_limit != 0 && m_cyc == int'(run_limit) - 1) m_state = 2;
        m_cyc = (m_cyc + 1) % (1 << RW);
      end else if (start) begin
        m_state = 1;
        m_cyc = 0;
        for (int i = 0; i < C; i++) begin
`ifdef FRSIM_TOGGLE_PHASE_EN
          m_cnt[i] = int'(phase[i*DW +: DW]);
`else
          m_cnt[i] = 0;
`endif
        end
      end
    end
    sbq.push_back({m_tog, m_edge, RW'(m_cyc),
                   m_state == 1, m_state == 2});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0;
    step(); void'(sbq.pop_front());
    rst = 1'b0;
  endtask

  task automatic test_reset();
    enable = 4'b1010; div = '0; run_limit = '0;
    do_reset();
    start = 1'b1; step(); start = 1'b0; step();
    repeat (2) void'(sbq.pop_front());
    n_cmp++;
    if (tog_o !== 4'b1010) begin
      n_bad++; $display("FAIL rst_pre tog=%b exp=1010", tog_o);
    end
    rst = 1'b1; start = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      e = sbq.pop_front();
      got = {tog_o, edge_o, cycles_o, busy_o, done_o};
      n_cmp++;
      if (got !== vec_t'(0) || e !== vec_t'(0)) begin
        n_bad++; $display("FAIL rst_clear k=%0d got=%h exp=0", k, got);
      end
    end
    rst = 1'b0; start = 1'b0;
  endtask

  task automatic test_divide();
    do_reset();
    enable = 4'hF; run_limit = 8'd40;
    div = {8'd3, 8'd2, 8'd1, 8'd0};
    start = 1'b1; step(); start = 1'b0;
    void'(sbq.pop_front());
    for (int k = 1; k <= 44; k++) begin
      step();
      e = sbq.pop_front();
      got = {tog_o, edge_o, cycles_o, busy_o, done_o};
      n_cmp++;
      if (got !== e) begin
        n_bad++; $display("FAIL div_sb k=%0d got=%h exp=%h", k, got, e);
      end
      if (k <= 40) begin
        n_cmp++;
        if (edge_o[3] !== (k % 4 == 0) ||
            tog_o[3] !== 1'((k / 4) % 2) ||
            tog_o[0] !== 1'(k % 2) || edge_o[0] !== 1'b1) begin
          n_bad++;
          $display("FAIL div_fixed k=%0d tog=%b edge=%b", k, tog_o, edge_o);
        end
      end
    end
  endtask

  task automatic test_run_length();
    int nbusy;
    do_reset();
    enable = 4'hF; div = {8'd3, 8'd2, 8'd1, 8'd0};
    run_limit = 8'd10;
    start = 1'b1; step(); start = 1'b0;
    nbusy = 0;
    for (int k = 0; k <= 14; k++) begin
      if (k > 0) step();
      e = sbq.pop_front();
      got = {tog_o, edge_o, cycles_o, busy_o, done_o};
      if (busy_o === 1'b1) nbusy++;
      n_cmp++;
      if (got !== e) begin
        n_bad++; $display("FAIL run_sb k=%0d got=%h exp=%h", k, got, e);
      end
      if (k == 9) begin
        n_cmp++;
        if (cycles_o !== 8'd9 || busy_o !== 1'b1) begin
          n_bad++; $display("FAIL run_last cycles=%0d exp=9", cycles_o);
        end
      end
      if (k >= 10) begin
        n_cmp++;
        if (done_o !== 1'b1 || busy_o !== 1'b0) begin
          n_bad++; $display("FAIL run_done k=%0d done=%b exp=1", k, done_o);
        end
      end
    end
    n_cmp++;
    if (nbusy != 10) begin
      n_bad++; $display("FAIL run_busycnt got=%0d exp=10", nbusy);
    end
    // Held start: restart now, then done lasts one cycle.
    start = 1'b1;
    for (int k = 0; k <= 11; k++) begin
      step();
      e = sbq.pop_front();
      got = {tog_o, edge_o, cycles_o, busy_o, done_o};
      n_cmp++;
      if (got !== e) begin
        n_bad++; $display("FAIL held_sb k=%0d got=%h exp=%h", k, got, e);
      end
      if (k == 0 || k == 11) begin
        n_cmp++;
        if (busy_o !== 1'b1 || cycles_o !== 8'd0) begin
          n_bad++;
          $display("FAIL restart k=%0d busy=%b cycles=%0d exp=1/0",
                   k, busy_o, cycles_o);
        end
      end
      if (k == 10) begin
        n_cmp++;
        if (done_o !== 1'b1) begin
          n_bad++; $display("FAIL done_pulse done=%b exp=1", done_o);
        end
      end
    end
    start = 1'b0;
  endtask

  task automatic test_free_run();
    int ndone;
    do_reset();
    run_limit = '0;
    start = 1'b1; step(); start = 1'b0;
    void'(sbq.pop_front());
    ndone = 0;
    for (int k = 1; k <= 300; k++) begin
      step();
      e = sbq.pop_front();
      got = {tog_o, edge_o, cycles_o, busy_o, done_o};
      if (done_o !== 1'b0) ndone++;
      if (got !== e) begin
        n_cmp++; n_bad++;
        $display("FAIL free_sb k=%0d got=%h exp=%h", k, got, e);
      end
      if (k == 256 || k == 300) begin
        n_cmp++;
        if (cycles_o !== 8'(k % 256) || busy_o !== 1'b1) begin
          n_bad++;
          $display("FAIL free_wrap k=%0d cycles=%0d exp=%0d",
                   k, cycles_o, k % 256);
        end
      end
    end
    n_cmp++;
    if (ndone != 0) begin
      n_bad++; $display("FAIL free_done count=%0d exp=0", ndone);
    end
  endtask

  task automatic test_enable_div();
    logic t1;
    int guard;
    do_reset();
    enable = 4'hF; run_limit = '0;
    div = {8'd1, 8'd7, 8'd2, 8'd0};
    start = 1'b1; step(); start = 1'b0;
    void'(sbq.pop_front());
    repeat (4) begin step(); void'(sbq.pop_front()); end
    t1 = m_tog[1];
    enable[1] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      e = sbq.pop_front();
      got = {tog_o, edge_o, cycles_o, busy_o, done_o};
      n_cmp++;
      if (got !== e || tog_o[1] !== t1 || edge_o[1] !== 1'b0) begin
        n_bad++; $display("FAIL en_freeze k=%0d got=%h exp=%h", k, got, e);
      end
    end
    enable[1] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      e = sbq.pop_front();
      got = {tog_o, edge_o, cycles_o, busy_o, done_o};
      n_cmp++;
      if (got !== e) begin
        n_bad++; $display("FAIL en_resume k=%0d got=%h exp=%h", k, got, e);
      end
    end
    guard = 0;
    while (m_cnt[2] != 5 && guard < 40) begin
      step(); void'(sbq.pop_front()); guard++;
    end
    n_cmp++;
    if (m_cnt[2] != 5) begin
      n_bad++; $display("FAIL div_wait cnt2=%0d exp=5", m_cnt[2]);
    end
    t1 = m_tog[2];
    div[2*DW +: DW] = 8'd2;
    step();
    e = sbq.pop_front();
    got = {tog_o, edge_o, cycles_o, busy_o, done_o};
    n_cmp++;
    if (got !== e || edge_o[2] !== 1'b1 || tog_o[2] !== ~t1) begin
      n_bad++; $display("FAIL div_lower got=%h exp=%h", got, e);
    end
  endtask

`ifdef FRSIM_TOGGLE_PHASE_EN
  task automatic test_phase();
    do_reset();
    enable = 4'hF; run_limit = '0;
    div = {4{8'd3}};
    phase = {8'd3, 8'd2, 8'd1, 8'd0};
    start = 1'b1; step(); start = 1'b0;
    void'(sbq.pop_front());
    for (int k = 1; k <= 4; k++) begin
      step();
      e = sbq.pop_front();
      got = {tog_o, edge_o, cycles_o, busy_o, done_o};
      n_cmp++;
      if (got !== e) begin
        n_bad++; $display("FAIL ph_sb k=%0d got=%h exp=%h", k, got, e);
      end
      for (int i = 0; i < C; i++) begin
        n_cmp++;
        if (edge_o[i] !== (k == 4 - i)) begin
          n_bad++;
          $display("FAIL ph_first k=%0d ch=%0d edge=%b", k, i, edge_o[i]);
        end
      end
    end
    do_reset();
    phase = {8'd0, 8'd0, 8'd0, 8'd5};
    start = 1'b1; step(); start = 1'b0; step();
    repeat (2) void'(sbq.pop_front());
    n_cmp++;
    if (edge_o[0] !== 1'b1 || tog_o[0] !== 1'b1) begin
      n_bad++; $display("FAIL ph_over edge=%b tog=%b exp=1/1",
                        edge_o[0], tog_o[0]);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; start = 1'b0; enable = '0; div = '0; run_limit = '0;
`ifdef FRSIM_TOGGLE_PHASE_EN
    phase = '0;
`endif
    #1;
    test_reset();
    test_divide();
    test_run_length();
    test_free_run();
    test_enable_div();
`ifdef FRSIM_TOGGLE_PHASE_EN
    test_phase();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
